// File: rtl/mips_top.sv
// Board shell for the single-cycle MIPS core: selectable step-rate clock enable,
// Go-button run/halt control, instruction counters and an 8-digit 7-segment display.

module mips_cpu (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        halt,
  output logic        branch_taken,
  output logic        jump,
  output logic        led_we,
  output logic [31:0] led_data
);
  localparam int unsigned XLEN = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;

  localparam logic [XLEN-1:0] SYS_HALT = 32'd10;
  localparam logic [XLEN-1:0] SYS_LED  = 32'd34;

  logic [XLEN-1:0] regs [32];
  logic [5:0]      op, funct;
  logic [4:0]      rs, rt, rd, shamt;
  logic [15:0]     imm;
  logic [XLEN-1:0] rs_val, rt_val, sext, pc_plus4, pc_next, wr_data;
  logic [4:0]      wr_addr;
  logic            wr_en;

  // Program ROM: halts after 10 instructions, then on resume writes the LEDs and halts again
  always_comb begin
    instr = '0;
    case (pc[31:2])
      30'd0:   instr = 32'h2002_000A;
      30'd1:   instr = 32'h1000_0001;
      30'd3:   instr = 32'h0800_0005;
      30'd5:   instr = 32'h1000_0001;
      30'd7:   instr = 32'h1000_0001;
      30'd9:   instr = 32'h2008_0001;
      30'd10:  instr = 32'h0800_000C;
      30'd12:  instr = 32'h2009_0002;
      30'd13:  instr = 32'h0109_5020;
      30'd14:  instr = 32'h0000_000C;
      30'd15:  instr = 32'h3C04_1234;
      30'd16:  instr = 32'h3484_5678;
      30'd17:  instr = 32'h2002_0022;
      30'd18:  instr = 32'h0000_000C;
      30'd19:  instr = 32'h2002_000A;
      30'd20:  instr = 32'h0000_000C;
      30'd21:  instr = 32'h0800_0000;
      default: instr = '0;
    endcase
  end

  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign sext     = {{16{imm[15]}}, imm};
  assign pc_plus4 = pc + 32'd4;
  assign rs_val   = (rs == 5'd0) ? '0 : regs[rs];
  assign rt_val   = (rt == 5'd0) ? '0 : regs[rt];
  assign led_data = regs[4];

  // Decode, execute and next-PC selection
  always_comb begin
    pc_next      = pc_plus4;
    wr_en        = 1'b0;
    wr_addr      = rt;
    wr_data      = '0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    halt         = 1'b0;
    led_we       = 1'b0;
    case (op)
      OP_RTYPE: begin
        wr_addr = rd;
        wr_en   = 1'b1;
        case (funct)
          FN_SLL:           wr_data = rt_val << shamt;
          FN_ADD, FN_ADDU:  wr_data = rs_val + rt_val;
          FN_SUB, FN_SUBU:  wr_data = rs_val - rt_val;
          FN_AND:           wr_data = rs_val & rt_val;
          FN_OR:            wr_data = rs_val | rt_val;
          FN_XOR:           wr_data = rs_val ^ rt_val;
          FN_NOR:           wr_data = ~(rs_val | rt_val);
          FN_SLT:           wr_data = XLEN'($signed(rs_val) < $signed(rt_val));
          FN_JR: begin
            wr_en   = 1'b0;
            jump    = 1'b1;
            pc_next = rs_val;
          end
          FN_SYSCALL: begin
            wr_en  = 1'b0;
            halt   = (regs[2] == SYS_HALT);
            led_we = (regs[2] == SYS_LED);
          end
          default: wr_en = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin wr_en = 1'b1; wr_data = rs_val + sext; end
      OP_SLTI:  begin wr_en = 1'b1; wr_data = XLEN'($signed(rs_val) < $signed(sext)); end
      OP_ANDI:  begin wr_en = 1'b1; wr_data = rs_val & {16'h0, imm}; end
      OP_ORI:   begin wr_en = 1'b1; wr_data = rs_val | {16'h0, imm}; end
      OP_LUI:   begin wr_en = 1'b1; wr_data = {imm, 16'h0}; end
      OP_BEQ, OP_BNE: begin
        if ((rs_val == rt_val) == (op == OP_BEQ)) begin
          branch_taken = 1'b1;
          pc_next      = pc_plus4 + (sext << 2);
        end
      end
      OP_J, OP_JAL: begin
        jump    = 1'b1;
        pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
        if (op == OP_JAL) begin
          wr_en   = 1'b1;
          wr_addr = 5'd31;
          wr_data = pc_plus4;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr && en && wr_en && (wr_addr != 5'd0)) regs[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (clr)     pc <= '0;
    else if (en) pc <= pc_next;
  end
endmodule

module mips_top #(
  parameter int unsigned DIV1      = 10,
  parameter int unsigned DIV2      = 20,
  parameter int unsigned DIV3      = 24,
  parameter int unsigned SCAN_BITS = 17
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       Go,
  input  logic [2:0] Show,
  input  logic [1:0] Hz,
  output logic       clk_N,
  output logic [7:0] SEG,
  output logic [7:0] AN
);
  localparam int unsigned CW = 32;
  localparam logic [CW-1:0] MASK1 = 32'((64'd1 << DIV1) - 64'd1);
  localparam logic [CW-1:0] MASK2 = 32'((64'd1 << DIV2) - 64'd1);
  localparam logic [CW-1:0] MASK3 = 32'((64'd1 << DIV3) - 64'd1);

  typedef enum logic {ST_RUN, ST_HALT} run_state_t;

  run_state_t           state, state_next;
  logic [CW-1:0]        div_cnt, count_all, count_branch, count_jmp, led_data_q, led_show;
  logic [SCAN_BITS-1:0] scan_cnt;
  logic                 s1, s2, go_edge, run, tick, step;
  logic [2:0]           digit;
  logic [3:0]           nibble;
  logic [31:0]          pc, instr, led_data;
  logic                 halt, branch_taken, jump, led_we;

  mips_cpu u_cpu (
    .clk          (clk),
    .clr          (clr),
    .en           (step),
    .pc           (pc),
    .instr        (instr),
    .halt         (halt),
    .branch_taken (branch_taken),
    .jump         (jump),
    .led_we       (led_we),
    .led_data     (led_data)
  );

  // Step-rate tick: every cycle, or once per 2^DIVn cycles of the free-running divider
  always_comb begin
    tick = 1'b1;
    case (Hz)
      2'd1:    tick = ((div_cnt & MASK1) == MASK1);
      2'd2:    tick = ((div_cnt & MASK2) == MASK2);
      2'd3:    tick = ((div_cnt & MASK3) == MASK3);
      default: tick = 1'b1;
    endcase
  end

  assign go_edge = s1 & ~s2;
  assign run     = (state == ST_RUN);
  assign step    = tick & run;

  // A halting step takes priority over a coincident Go edge
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:  if (step && halt) state_next = ST_HALT;
      ST_HALT: if (go_edge) state_next = ST_RUN;
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state <= ST_RUN;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      div_cnt      <= '0;
      scan_cnt     <= '0;
      s1           <= 1'b0;
      s2           <= 1'b0;
      clk_N        <= 1'b0;
      count_all    <= '0;
      count_branch <= '0;
      count_jmp    <= '0;
      led_data_q   <= '0;
    end else begin
      div_cnt  <= div_cnt + 32'd1;
      scan_cnt <= scan_cnt + SCAN_BITS'(1);
      s1       <= Go;
      s2       <= s1;
      if (tick) clk_N <= ~clk_N;
      if (step) begin
        count_all <= count_all + 32'd1;
        if (branch_taken) count_branch <= count_branch + 32'd1;
        if (jump)         count_jmp    <= count_jmp + 32'd1;
        if (led_we)       led_data_q   <= led_data;
      end
    end
  end

  always_comb begin
    led_show = '0;
    case (Show)
      3'd0:    led_show = led_data_q;
      3'd1:    led_show = count_all;
      3'd2:    led_show = count_branch;
      3'd3:    led_show = count_jmp;
      3'd4:    led_show = pc;
      3'd5:    led_show = instr;
      default: led_show = '0;
    endcase
  end

  assign digit  = scan_cnt[SCAN_BITS-1 -: 3];
  assign nibble = 4'(led_show >> {digit, 2'b00});
  assign AN     = ~(8'd1 << digit);

  // Active-low hex decoder, dp held off
  always_comb begin
    SEG = 8'hFF;
    case (nibble)
      4'h0: SEG = 8'hC0;
      4'h1: SEG = 8'hF9;
      4'h2: SEG = 8'hA4;
      4'h3: SEG = 8'hB0;
      4'h4: SEG = 8'h99;
      4'h5: SEG = 8'h92;
      4'h6: SEG = 8'h82;
      4'h7: SEG = 8'hF8;
      4'h8: SEG = 8'h80;
      4'h9: SEG = 8'h90;
      4'hA: SEG = 8'h88;
      4'hB: SEG = 8'h83;
      4'hC: SEG = 8'hC6;
      4'hD: SEG = 8'hA1;
      4'hE: SEG = 8'h86;
      4'hF: SEG = 8'h8E;
      default: SEG = 8'hFF;
    endcase
  end
endmodule

// File: tb/tb_mips_top.sv
// Self-checking bench for mips_top: a program-level reference model predicts every
// displayed digit, AN and clk_N each cycle under directed and random stimulus.

module tb_mips_top;
  localparam int unsigned DIV1 = 2;
  localparam int unsigned DIV2 = 3;
  localparam int unsigned DIV3 = 4;
  localparam int unsigned SCAN_BITS = 3;
  localparam int unsigned NPROG = 22;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       Go = 1'b0;
  logic [2:0] Show = 3'd0;
  logic [1:0] Hz = 2'd0;
  logic       clk_N;
  logic [7:0] SEG, AN;

  mips_top #(.DIV1(DIV1), .DIV2(DIV2), .DIV3(DIV3), .SCAN_BITS(SCAN_BITS)) dut (
    .clk   (clk),
    .clr   (clr),
    .Go    (Go),
    .Show  (Show),
    .Hz    (Hz),
    .clk_N (clk_N),
    .SEG   (SEG),
    .AN    (AN)
  );

  always #10 clk = ~clk;

  // Program as seen at the instruction level: word, successor, and its effect
  logic [31:0] prog_word [NPROG] = '{
    32'h2002000A, 32'h10000001, 32'h00000000, 32'h08000005, 32'h00000000, 32'h10000001,
    32'h00000000, 32'h10000001, 32'h00000000, 32'h20080001, 32'h0800000C, 32'h00000000,
    32'h20090002, 32'h01095020, 32'h0000000C, 32'h3C041234, 32'h34845678, 32'h20020022,
    32'h0000000C, 32'h2002000A, 32'h0000000C, 32'h08000000};
  int unsigned prog_next [NPROG] = '{
    1, 3, 3, 5, 5, 7, 7, 9, 9, 10, 12, 12, 13, 14, 15, 16, 17, 18, 19, 20, 21, 0};
  logic [6:0] hex_pat [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [7:0] led_scan [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};

  int unsigned m_div, m_scan, m_pc, m_all, m_br, m_jmp;
  logic [31:0] m_led;
  bit          m_s1, m_s2, m_run, m_clkn;
  int          tests = 0;
  int          fails = 0;

  task automatic model_reset();
    m_div = 0; m_scan = 0; m_pc = 0; m_all = 0; m_br = 0; m_jmp = 0;
    m_led = 32'h0; m_s1 = 1'b0; m_s2 = 1'b0; m_run = 1'b1; m_clkn = 1'b0;
  endtask

  // One clk edge of the reference, using the inputs present at that edge
  task automatic model_edge();
    int unsigned per;
    bit tick, step;
    if (clr) begin
      model_reset();
      return;
    end
    case (Hz)
      2'd1:    per = 1 << DIV1;
      2'd2:    per = 1 << DIV2;
      2'd3:    per = 1 << DIV3;
      default: per = 1;
    endcase
    tick = ((m_div % per) == per - 1);
    step = tick && m_run;
    if (step) begin
      if (m_pc inside {14, 20}) m_run = 1'b0;
      m_all++;
      if (m_pc inside {1, 5, 7})   m_br++;
      if (m_pc inside {3, 10, 21}) m_jmp++;
      if (m_pc == 18) m_led = 32'h12345678;
      m_pc = prog_next[m_pc];
    end else if (m_s1 && !m_s2 && !m_run) begin
      m_run = 1'b1;
    end
    m_s2 = m_s1;
    m_s1 = Go;
    if (tick) m_clkn = ~m_clkn;
    m_div++;
    m_scan = (m_scan + 1) % (1 << SCAN_BITS);
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] val;
    logic [3:0]  nib;
    logic [7:0]  e_an, e_seg;
    int unsigned dig;
    case (Show)
      3'd0:    val = m_led;
      3'd1:    val = 32'(m_all);
      3'd2:    val = 32'(m_br);
      3'd3:    val = 32'(m_jmp);
      3'd4:    val = 32'(m_pc * 4);
      3'd5:    val = prog_word[m_pc];
      default: val = 32'h0;
    endcase
    dig   = m_scan >> (SCAN_BITS - 3);
    e_an  = ~(8'd1 << dig);
    nib   = 4'(val >> (4 * dig));
    e_seg = {1'b1, hex_pat[nib]};
    tests++;
    assert (AN === e_an) else begin
      fails++; $error("FAIL %s AN got %h want %h", tag, AN, e_an);
    end
    tests++;
    assert (SEG === e_seg) else begin
      fails++; $error("FAIL %s SEG got %h want %h (show %0d digit %0d)", tag, SEG, e_seg, Show, dig);
    end
    tests++;
    assert (clk_N === m_clkn) else begin
      fails++; $error("FAIL %s clk_N got %b want %b", tag, clk_N, m_clkn);
    end
  endtask

  task automatic step_cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic run_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) step_cycle(tag);
  endtask

  task automatic expect_seg(input logic [7:0] want, input string tag);
    tests++;
    assert (SEG === want) else begin
      fails++; $error("FAIL %s SEG got %h want %h", tag, SEG, want);
    end
  endtask

  task automatic align_digit0();
    for (int i = 0; i < 8 && m_scan != 0; i++) step_cycle("align");
  endtask

  initial begin
    model_reset();
    clr = 1'b1;
    run_cycles(3, "reset");
    tests++;
    assert (AN === 8'hFE) else begin fails++; $error("FAIL reset_an got %h want fe", AN); end
    expect_seg(8'hC0, "reset_seg");
    tests++;
    assert (clk_N === 1'b0) else begin fails++; $error("FAIL reset_clkn got %b want 0", clk_N); end

    // Full speed until the first halt (10 instructions)
    clr = 1'b0; Show = 3'd1;
    run_cycles(14, "run_to_halt");
    align_digit0();
    Show = 3'd1; #1; expect_seg(8'h88, "halt_count_all");
    Show = 3'd2; #1; expect_seg(8'hB0, "halt_count_branch");
    Show = 3'd3; #1; expect_seg(8'hA4, "halt_count_jmp");
    run_cycles(16, "halted_frozen");

    // Short Go pulse resumes once; runs through the LED write to the next halt
    Go = 1'b1; run_cycles(2, "go_pulse");
    Go = 1'b0; run_cycles(12, "resume");
    Show = 3'd0;
    align_digit0();
    for (int i = 0; i < 8; i++) begin
      expect_seg(led_scan[i], "led_scan_seg");
      tests++;
      assert (AN === ~(8'd1 << i)) else begin fails++; $error("FAIL led_scan_an got %h digit %0d", AN, i); end
      step_cycle("led_scan");
    end

    // Held Go gives exactly one resume
    Show = 3'd1; Go = 1'b1; run_cycles(30, "go_held");
    Go = 1'b0; run_cycles(4, "go_release");

    // Slower step rates
    Go = 1'b1; run_cycles(2, "go_slow");
    Go = 1'b0; Hz = 2'd1; run_cycles(40, "hz1");
    Hz = 2'd2; Show = 3'd4; run_cycles(30, "hz2");
    Hz = 2'd3; Show = 3'd5; run_cycles(40, "hz3");

    // Reset in the middle of running
    Hz = 2'd0; Show = 3'd4; Go = 1'b1; run_cycles(3, "pre_clr");
    Go = 1'b0; run_cycles(3, "pre_clr");
    clr = 1'b1; step_cycle("mid_clr");
    expect_seg(8'hC0, "mid_clr_pc");
    tests++;
    assert (AN === 8'hFE) else begin fails++; $error("FAIL mid_clr_an got %h want fe", AN); end
    clr = 1'b0;
    run_cycles(5, "post_clr");

    // Randomized inputs against the reference
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0)   Show = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0)  Hz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0)  Go = ~Go;
      clr = ($urandom_range(0, 399) == 0);
      step_cycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
